// File: rtl/npu_axis_pkg.sv
// Shared types and defaults for the NPU AXI-Stream output path.
package npu_axis_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_MAX_ADDR_WIDTH = 16;
    localparam int BANK_W             = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/axi_stream_output_if.sv
// AXI-Stream master/slave bundle carried between the output engine and the host link.
interface axi_stream_output_if
    import npu_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic signed [DATA_WIDTH-1:0]   tdata;
    logic        [DATA_WIDTH/8-1:0] tstrb;
    logic                           tvalid;
    logic                           tready;
    logic                           tlast;

    modport master (output tdata, tstrb, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_out_fifo.sv
// Small synchronous FIFO holding {last, data} beats in front of the stream port.
module axis_out_fifo
    import npu_axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [CW-1:0]         count,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                pop_ok;

    assign pop_ok    = pop && !empty;
    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head_data = mem[rd_ptr][DATA_WIDTH-1:0];
    assign head_last = mem[rd_ptr][DATA_WIDTH];

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/axi_stream_output.sv
// Drains a result SRAM bank onto an AXI-Stream master port with credit-limited reads.
// Optional stall_cycles counter is built when AXIS_OUTPUT_STALL_CNT_EN is defined.
module axi_stream_output
    import npu_axis_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int MAX_ADDR_WIDTH = DEF_MAX_ADDR_WIDTH,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        m_axis_aclk,
    input  logic                        m_axis_areset,
    input  logic                        start,
    input  logic [MAX_ADDR_WIDTH-1:0]   base_address,
    input  logic [MAX_ADDR_WIDTH-1:0]   length,
    input  logic [BANK_W-1:0]           data_type,
    output logic                        read_enable,
    output logic [MAX_ADDR_WIDTH-1:0]   read_address,
    output logic [BANK_W-1:0]           read_bank,
    input  logic signed [DATA_WIDTH-1:0] read_data,
    output logic                        busy,
    output logic                        done,
`ifdef AXIS_OUTPUT_STALL_CNT_EN
    output logic [31:0]                 stall_cycles,
`endif
    axi_stream_output_if.master         m_axis
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                    state;
    logic [MAX_ADDR_WIDTH-1:0] rd_addr, rd_left;
    logic [BANK_W-1:0]         bank;
    logic                      rd_q, rd_last_q;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_empty, fifo_full;
    logic                      issue, pop;
    logic [DATA_WIDTH-1:0]     head_data;
    logic                      head_last;

    // A read lands in the FIFO one cycle after issue, so the previous read is a held credit.
    assign issue = (state == ST_READ) && !fifo_full &&
                   ((int'(fifo_count) + int'(rd_q)) < FIFO_DEPTH);
    assign pop   = !fifo_empty && m_axis.tready;

    assign read_enable  = issue;
    assign read_address = rd_addr;
    assign read_bank    = bank;
    assign busy         = (state != ST_IDLE);

    assign m_axis.tvalid = !fifo_empty;
    assign m_axis.tdata  = head_data;
    assign m_axis.tlast  = head_last;
    assign m_axis.tstrb  = {(DATA_WIDTH/8){!fifo_empty}};

    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state     <= ST_IDLE;
            rd_addr   <= '0;
            rd_left   <= '0;
            bank      <= '0;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_q      <= issue;
            rd_last_q <= issue && (rd_left == MAX_ADDR_WIDTH'(1));
            done      <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    bank <= data_type;
                    if (length != '0) begin
                        state   <= ST_READ;
                        rd_addr <= base_address;
                        rd_left <= length;
                    end else begin
                        done <= 1'b1;
                    end
                end
                ST_READ: if (issue) begin
                    rd_addr <= rd_addr + 1'b1;
                    rd_left <= rd_left - 1'b1;
                    if (rd_left == MAX_ADDR_WIDTH'(1))
                        state <= ST_DRAIN;
                end
                ST_DRAIN: if (pop && head_last) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_out_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (m_axis_aclk),
        .rst       (m_axis_areset),
        .push      (rd_q),
        .push_data (read_data),
        .push_last (rd_last_q),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef AXIS_OUTPUT_STALL_CNT_EN
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset)
            stall_cycles <= '0;
        else if (state == ST_IDLE && start)
            stall_cycles <= '0;
        else if (busy && m_axis.tvalid && !m_axis.tready && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule
